fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 10: program-counter width.
REQ-002 SHALL have parameter START_PC, default 0: PC value loaded on reset and on Start.
REQ-003 SHALL have port Clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1: level; high forces PC to START_PC and holds the core idle.
REQ-006 SHALL have port Stall  input  1: freezes PC and state for the cycle.
REQ-007 SHALL have port Halt  input  1: current instruction is the halt; stop fetching.
REQ-008 SHALL have port BrReq  input  1: current instruction is a branch.
REQ-009 SHALL have port BrTaken  input  1: branch condition true; qualified by BrReq.
REQ-010 SHALL have port BrRel  input  1: 1 = PC-relative target, 0 = absolute target.
REQ-011 SHALL have port BrIdx  input  4: branch-target table index from the instruction.
REQ-012 SHALL have port LutAddr  output  4: registered index driven to the target lookup table.
REQ-013 SHALL have port Target  input  16: lookup-table result for LutAddr, combinational, valid the cycle after LutAddr updates.
REQ-014 SHALL have port ProgCtr  output  PC_W: registered instruction address.
REQ-015 SHALL have port FetchValid  output  1: ProgCtr addresses an instruction to execute this cycle.
REQ-016 SHALL have port Done  output  1: program finished; held until Start.

Function
REQ-017 SHALL implement states IDLE, RUN, BR_WAIT, DONE, plus a registered Armed flag.
REQ-018 Priority in every state SHALL be Start > Stall > Halt > taken branch > increment.
REQ-019 Start=1 in any state SHALL set state=IDLE, ProgCtr=START_PC, Armed=1, Done=0 next edge.
REQ-020 IDLE with Start=0 and Armed=1 SHALL go to RUN next edge with ProgCtr unchanged; Armed=0 SHALL keep IDLE.
REQ-021 Stall=1 (Start=0) SHALL hold state, ProgCtr, LutAddr; FetchValid follows the held state.
REQ-022 FetchValid SHALL be 1 only in RUN; 0 in IDLE, BR_WAIT, DONE.
REQ-023 RUN, Halt=1: next state DONE, ProgCtr unchanged.
REQ-024 RUN, BrReq=1 and BrTaken=1: LutAddr<=BrIdx, latch BrRel, next state BR_WAIT, ProgCtr unchanged.
REQ-025 RUN, otherwise (incl. BrReq=1, BrTaken=0): ProgCtr<=ProgCtr+1, wrapping 2^PC_W-1 -> 0.
REQ-026 BR_WAIT, latched BrRel=0: ProgCtr<=Target[PC_W-1:0] (upper bits ignored); next RUN.
REQ-027 BR_WAIT, latched BrRel=1: ProgCtr<=(ProgCtr+Target[PC_W-1:0]) mod 2^PC_W, Target two's complement (16'hFFFF = -1); next RUN.
REQ-028 Branch-taken penalty SHALL be exactly one non-valid cycle (BR_WAIT) absent Stall.
REQ-029 DONE: Done=1, ProgCtr held; leaves only via Start.
REQ-030 Halt and BrReq together in RUN: Halt wins, no LutAddr update.

Reset
REQ-031 Reset=1 SHALL immediately force state=IDLE, ProgCtr=START_PC, LutAddr=0, latched BrRel=0, Armed=0, FetchValid=0, Done=0.
REQ-032 Reset asserted mid-branch (BR_WAIT) SHALL discard the pending branch; no PC update after release.
REQ-033 After Reset release, core SHALL stay IDLE until Start has been high at least one edge then low.

Verification
REQ-034 Reset, Start high 2 cycles then low -> IDLE, then RUN; ProgCtr 0,1,2,3 with FetchValid=1 from first RUN cycle.
REQ-035 At ProgCtr=5, BrReq=BrTaken=1, BrRel=0, BrIdx=3, Target=61 -> LutAddr=3, one cycle FetchValid=0, then ProgCtr=61.
REQ-036 At ProgCtr=10, relative branch, Target=16'hFFFF -> ProgCtr=9; at ProgCtr=0, Target=16'hFFFF -> 1023 (wrap).
REQ-037 BrReq=1, BrTaken=0 at ProgCtr=7 -> ProgCtr=8, LutAddr unchanged; Stall=1 for 3 cycles -> ProgCtr frozen, resumes +1.
REQ-038 Halt=1 at ProgCtr=20 with BrReq=1 -> DONE, Done=1, ProgCtr=20 held; Start pulse -> ProgCtr=0, Done=0.
REQ-039 Reset asserted in BR_WAIT asynchronously -> outputs at reset values before next edge; no jump after release.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. It steps the program counter,
//                resolves taken branches through an external target lookup
//                table (one wait cycle), and supports stall, halt and restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int PC_W     = 10,
    parameter int START_PC = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            Halt,
    input  logic            BrReq,
    input  logic            BrTaken,
    input  logic            BrRel,
    input  logic [3:0]      BrIdx,
    output logic [3:0]      LutAddr,
    input  logic [15:0]     Target,
    output logic [PC_W-1:0] ProgCtr,
    output logic            FetchValid,
    output logic            Done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_BR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] c_START_PC = PC_W'(START_PC);

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [3:0]      r_lut_addr, w_lut_addr_nxt;
    logic            r_br_rel, w_br_rel_nxt;
    logic            r_armed, w_armed_nxt;

    // Only the low PC_W bits of the table entry form a target; a relative
    // offset in two's complement wraps correctly using just these bits.
    logic [PC_W-1:0] w_tgt;
    assign w_tgt = Target[PC_W-1:0];

    generate
        if (PC_W < 16) begin : g_unused_target
            logic w_unused_tgt;
            assign w_unused_tgt = ^Target[15:PC_W];
        end
    endgenerate

    // State and datapath registers; reset drops any branch in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_pc       <= c_START_PC;
            r_lut_addr <= 4'd0;
            r_br_rel   <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_lut_addr <= w_lut_addr_nxt;
            r_br_rel   <= w_br_rel_nxt;
            r_armed    <= w_armed_nxt;
        end
    end

    // Next-state logic: Start > Stall > Halt > taken branch > increment.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_lut_addr_nxt = r_lut_addr;
        w_br_rel_nxt   = r_br_rel;
        w_armed_nxt    = r_armed;

        if (Start) begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = c_START_PC;
            w_armed_nxt = 1'b1;
        end else if (!Stall) begin
            case (r_state)
                S_IDLE: begin
                    // Armed only by a Start that has since been released.
                    if (r_armed) begin
                        w_state_nxt = S_RUN;
                        w_armed_nxt = 1'b0;
                    end
                end
                S_RUN: begin
                    if (Halt) begin
                        w_state_nxt = S_DONE;
                    end else if (BrReq && BrTaken) begin
                        w_lut_addr_nxt = BrIdx;
                        w_br_rel_nxt   = BrRel;
                        w_state_nxt    = S_BR_WAIT;
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
                S_BR_WAIT: begin
                    // Table output for the latched index is valid now.
                    w_pc_nxt    = r_br_rel ? (r_pc + w_tgt) : w_tgt;
                    w_state_nxt = S_RUN;
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign LutAddr    = r_lut_addr;
    assign ProgCtr    = r_pc;
    assign FetchValid = (r_state == S_RUN);
    assign Done       = (r_state == S_DONE);

endmodule
`default_nettype wire
